// File: rtl/init_seq_pkg.sv
// Shared types, state encodings and defaults for the init/iteration sequencer.
package init_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Legacy-compatible state encodings used by the sequencer register
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned DEF_PRESCALE = 50000;
  localparam int unsigned DEF_DEB_LEN  = 6;
  localparam int unsigned DEF_ITER_N   = 18;

  // Width of the dropped-start counter (only used with INIT_SEQ_OVERRUN_EN)
  localparam int unsigned OVR_W = 8;

  // Counter width able to hold 0..iter_n
  function automatic int unsigned cnt_width(input int unsigned iter_n);
    return 32'($clog2(iter_n + 32'd1));
  endfunction

endpackage

// File: rtl/init_seq_if.sv
// Handshake / status bundle between the sequencer and its user.
// Optional macro INIT_SEQ_OVERRUN_EN adds the ovr_cnt status bus.
interface init_seq_if
  import init_seq_pkg::*;
#(
  parameter int unsigned CW = 5
) ();

  logic          free_run_i;
  logic          start_i;
  logic          core_rst;
  logic          key_evt;
  logic          busy;
  logic [CW-1:0] cnt;
  logic          cnt_start_dly;
  logic          cnt_last;
  logic          cnt_over;
`ifdef INIT_SEQ_OVERRUN_EN
  logic [OVR_W-1:0] ovr_cnt;
`endif

`ifdef INIT_SEQ_OVERRUN_EN
  // Requester side: issues run control, observes status
  modport master (
    output free_run_i, start_i,
    input  core_rst, key_evt, busy, cnt, cnt_start_dly, cnt_last, cnt_over, ovr_cnt
  );
  // Sequencer side
  modport slave (
    input  free_run_i, start_i,
    output core_rst, key_evt, busy, cnt, cnt_start_dly, cnt_last, cnt_over, ovr_cnt
  );
`else
  // Requester side: issues run control, observes status
  modport master (
    output free_run_i, start_i,
    input  core_rst, key_evt, busy, cnt, cnt_start_dly, cnt_last, cnt_over
  );
  // Sequencer side
  modport slave (
    input  free_run_i, start_i,
    output core_rst, key_evt, busy, cnt, cnt_start_dly, cnt_last, cnt_over
  );
`endif

endinterface

// File: rtl/key_debounce.sv
// Key conditioner: synchroniser, sampling prescaler, release detector and
// power-on hold. core_rst_pre is a raw decode; the top registers it.
module key_debounce
  import init_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned DEB_LEN  = DEF_DEB_LEN,
  parameter int unsigned SIM      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic core_rst_pre,
  output logic key_evt
);

  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic        SIM_TICK = (SIM != 0);

  logic               key_meta;
  logic               key_sync;
  logic [PW-1:0]      pre_cnt;
  logic               pre_wrap;
  logic               tick;
  logic [DEB_LEN-1:0] hist;
  logic               match;
  logic               match_q;
  logic               init_hold;
  logic               key_evt_q;

  // Two-flop synchroniser for the asynchronous key level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= key_i;
      key_sync <= key_meta;
    end
  end

  assign pre_wrap = (pre_cnt == PW'(PRESCALE - 1));
  assign tick     = SIM_TICK | pre_wrap;

  // Sampling prescaler, wraps at PRESCALE-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_wrap) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Key history, one sample per tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (tick) begin
      hist <= {hist[DEB_LEN-2:0], key_sync};
    end
  end

  // A single pressed sample followed by DEB_LEN-1 released samples
  assign match = hist[DEB_LEN-1] & ~|hist[DEB_LEN-2:0];

  // Rising-edge detect of match gives the one-clock key event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q   <= 1'b0;
      key_evt_q <= 1'b0;
    end else begin
      match_q   <= match;
      key_evt_q <= match & ~match_q;
    end
  end

  // Power-on hold, released by the first tick after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_hold <= 1'b1;
    end else if (tick) begin
      init_hold <= 1'b0;
    end
  end

  assign core_rst_pre = match | init_hold;
  assign key_evt      = key_evt_q;

endmodule

// File: rtl/init_seq_ctrl.sv
// Reset conditioner plus 0..ITER_N iteration sequencer for iterative datapaths.
// Optional macro INIT_SEQ_OVERRUN_EN adds a saturating dropped-start counter.
module init_seq_ctrl
  import init_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned DEB_LEN  = DEF_DEB_LEN,
  parameter int unsigned ITER_N   = DEF_ITER_N,
  parameter int unsigned SIM      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_i,
  init_seq_if.slave  bus
);

  localparam int unsigned   CW       = cnt_width(ITER_N);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER_N - 1);
  localparam logic [CW-1:0] CNT_OVER = CW'(ITER_N);

  logic          core_rst_pre;
  logic          key_evt_w;
  logic          core_rst_q;
  logic [0:0]    state_q;
  logic [0:0]    state_n;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic          busy_q;
  logic          busy_n;
  logic          last_q;
  logic          last_n;
  logic          over_q;
  logic          over_n;
  logic          start_dly_q;
  logic          start_dly_n;

  key_debounce #(
    .PRESCALE (PRESCALE),
    .DEB_LEN  (DEB_LEN),
    .SIM      (SIM)
  ) u_key_debounce (
    .clk          (clk),
    .rst          (rst),
    .key_i        (key_i),
    .core_rst_pre (core_rst_pre),
    .key_evt      (key_evt_w)
  );

  // Registered downstream reset; asserted out of rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst_q <= 1'b1;
    end else begin
      core_rst_q <= core_rst_pre;
    end
  end

  // Sequencer next state, counter and flag decode
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    start_dly_n = 1'b0;
    if (core_rst_q) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      start_dly_n = (state_q == ST_RUN) && (cnt_q == '0);
      case (state_q)
        ST_IDLE: begin
          if (bus.free_run_i || bus.start_i) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_OVER) begin
            cnt_n = '0;
            if (!bus.free_run_i) begin
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    // Flags are decoded from the next state so they register in step with cnt
    busy_n = (state_n == ST_RUN);
    last_n = busy_n && (cnt_n == CNT_LAST);
    over_n = busy_n && (cnt_n == CNT_OVER);
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      last_q      <= 1'b0;
      over_q      <= 1'b0;
      start_dly_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      busy_q      <= busy_n;
      last_q      <= last_n;
      over_q      <= over_n;
      start_dly_q <= start_dly_n;
    end
  end

`ifdef INIT_SEQ_OVERRUN_EN
  logic             drop_c;
  logic [OVR_W-1:0] ovr_q;

  // A start request is lost whenever the sequencer is already running
  assign drop_c = bus.start_i && !core_rst_q && (state_q == ST_RUN);

  // Saturating dropped-start counter, cleared by core reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (core_rst_q) begin
      ovr_q <= '0;
    end else if (drop_c && (ovr_q != '1)) begin
      ovr_q <= ovr_q + OVR_W'(1);
    end
  end

  assign bus.ovr_cnt = ovr_q;
`endif

  assign bus.core_rst      = core_rst_q;
  assign bus.key_evt       = key_evt_w;
  assign bus.busy          = busy_q;
  assign bus.cnt           = cnt_q;
  assign bus.cnt_start_dly = start_dly_q;
  assign bus.cnt_last      = last_q;
  assign bus.cnt_over      = over_q;

endmodule

// File: tb/tb_init_seq_ctrl.sv
// Directed bench for init_seq_ctrl: a PRESCALE=4 instance and a SIM=1 instance.
module tb_init_seq_ctrl;
  import init_seq_pkg::*;

  localparam int unsigned ITER_N = 18;
  localparam int unsigned CW     = cnt_width(ITER_N);

  logic clk = 1'b0;
  logic rst;
  logic key_i;
  logic rst_s;
  logic key_s;

  int total = 0;
  int bad   = 0;

  init_seq_if #(.CW(CW)) bus ();
  init_seq_if #(.CW(CW)) bus_s ();

  init_seq_ctrl #(
    .PRESCALE (4),
    .DEB_LEN  (6),
    .ITER_N   (ITER_N),
    .SIM      (0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key_i (key_i),
    .bus   (bus)
  );

  init_seq_ctrl #(
    .PRESCALE (4),
    .DEB_LEN  (6),
    .ITER_N   (ITER_N),
    .SIM      (1)
  ) dut_sim (
    .clk   (clk),
    .rst   (rst_s),
    .key_i (key_s),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; rst_s = 1'b1; key_i = 1'b0; key_s = 1'b0;
    bus.free_run_i = 1'b0;   bus.start_i = 1'b0;
    bus_s.free_run_i = 1'b0; bus_s.start_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%0b exp=1", bus.core_rst); end
    total++; if ({bus.busy, bus.key_evt, bus.cnt_start_dly, bus.cnt_last, bus.cnt_over} !== 5'b0)
      begin bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.busy, bus.key_evt, bus.cnt_start_dly, bus.cnt_last, bus.cnt_over}); end
    total++; if (bus.cnt !== CW'(0)) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.cnt); end
`ifdef INIT_SEQ_OVERRUN_EN
    total++; if (bus.ovr_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovr got=%0d exp=0", bus.ovr_cnt); end
`endif
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL reset_hold got=%0b exp=1", bus.core_rst); end
    repeat (4) @(negedge clk);
    total++; if (bus.core_rst !== 1'b0) begin bad++; $display("FAIL reset_release got=%0b exp=0", bus.core_rst); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_free_run();
    int w;
    int e;
    logic [3:0] flg;
    bus.free_run_i = 1'b1;
    w = 0;
    while (bus.busy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL free_run_start got=%0b exp=1", bus.busy); end
    for (int i = 0; i < 38; i++) begin
      e = i % 19;
      total++; if (bus.cnt !== CW'(e)) begin bad++; $display("FAIL free_run_cnt i=%0d got=%0d exp=%0d", i, bus.cnt, e); end
      flg = {1'b1, (e == 17), (e == 18), (e == 1)};
      total++; if ({bus.busy, bus.cnt_last, bus.cnt_over, bus.cnt_start_dly} !== flg)
        begin bad++; $display("FAIL free_run_flags i=%0d got=%b exp=%b", i, {bus.busy, bus.cnt_last, bus.cnt_over, bus.cnt_start_dly}, flg); end
      @(negedge clk);
    end
  endtask

  task automatic test_triggered();
    int w;
    int overs;
    bus.free_run_i = 1'b0;
    w = 0;
    while (bus.busy !== 1'b0 && w < 40) begin @(negedge clk); w++; end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL trig_stop got=%0b exp=0", bus.busy); end
    @(negedge clk);
    total++; if ({bus.busy, bus.cnt} !== {1'b0, CW'(0)}) begin bad++; $display("FAIL trig_idle busy=%0b cnt=%0d exp 0/0", bus.busy, bus.cnt); end
    // run with a second start at cnt=7
    bus.start_i = 1'b1;
    @(negedge clk);
    overs = 0;
    for (int i = 0; i < 19; i++) begin
      total++; if ({bus.busy, bus.cnt} !== {1'b1, CW'(i)}) begin bad++; $display("FAIL trig_run i=%0d busy=%0b cnt=%0d exp 1/%0d", i, bus.busy, bus.cnt, i); end
      if (bus.cnt_over === 1'b1) overs++;
      bus.start_i = (i == 7);
      @(negedge clk);
    end
    total++; if ({bus.busy, bus.cnt} !== {1'b0, CW'(0)}) begin bad++; $display("FAIL trig_done busy=%0b cnt=%0d exp 0/0", bus.busy, bus.cnt); end
    total++; if (overs !== 1) begin bad++; $display("FAIL trig_over_count got=%0d exp=1", overs); end
`ifdef INIT_SEQ_OVERRUN_EN
    total++; if (bus.ovr_cnt !== 8'd1) begin bad++; $display("FAIL trig_ovr1 got=%0d exp=1", bus.ovr_cnt); end
`endif
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL trig_stay_idle got=%0b exp=0", bus.busy); end
    // run with start on the cnt_over clock
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 19; i++) begin
      total++; if (bus.cnt !== CW'(i)) begin bad++; $display("FAIL trig2_cnt i=%0d got=%0d exp=%0d", i, bus.cnt, i); end
      bus.start_i = (i == 18);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL trig_over_drop got=%0b exp=0", bus.busy); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL trig_rearm got=%0b exp=0", bus.busy); end
`ifdef INIT_SEQ_OVERRUN_EN
    total++; if (bus.ovr_cnt !== 8'd2) begin bad++; $display("FAIL trig_ovr2 got=%0d exp=2", bus.ovr_cnt); end
`endif
  endtask

  task automatic test_key();
    int w;
    int hi;
    bus.free_run_i = 1'b1;
    w = 0;
    while (bus.busy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    key_i = 1'b1;
    repeat (4) @(negedge clk);
    key_i = 1'b0;
    w = 0;
    while (bus.key_evt !== 1'b1 && w < 60) begin @(negedge clk); w++; end
    total++; if (w < 20 || w > 23) begin bad++; $display("FAIL key_evt_latency got=%0d exp=20..23", w); end
    total++; if ({bus.key_evt, bus.core_rst, bus.busy} !== 3'b111)
      begin bad++; $display("FAIL key_evt_edge got=%b exp=111", {bus.key_evt, bus.core_rst, bus.busy}); end
    hi = 0;
    while (bus.core_rst === 1'b1 && hi < 20) begin
      if (hi == 1) begin
        total++; if ({bus.key_evt, bus.busy, bus.cnt_start_dly} !== 3'b000 || bus.cnt !== CW'(0))
          begin bad++; $display("FAIL key_abort evt/busy/sd=%b cnt=%0d exp 000/0", {bus.key_evt, bus.busy, bus.cnt_start_dly}, bus.cnt); end
      end
      hi++;
      @(negedge clk);
    end
    total++; if (hi !== 4) begin bad++; $display("FAIL key_core_rst_len got=%0d exp=4", hi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL key_idle_after got=%0b exp=0", bus.busy); end
    @(negedge clk);
    total++; if ({bus.busy, bus.cnt} !== {1'b1, CW'(0)}) begin bad++; $display("FAIL key_restart busy=%0b cnt=%0d exp 1/0", bus.busy, bus.cnt); end
  endtask

  task automatic test_async_reset();
    int w;
    w = 0;
    while (bus.cnt !== CW'(9) && w < 40) begin @(negedge clk); w++; end
    total++; if ({bus.busy, bus.cnt} !== {1'b1, CW'(9)}) begin bad++; $display("FAIL arst_reach busy=%0b cnt=%0d exp 1/9", bus.busy, bus.cnt); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.cnt !== CW'(0)) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", bus.cnt); end
    total++; if ({bus.core_rst, bus.busy, bus.key_evt, bus.cnt_start_dly, bus.cnt_last, bus.cnt_over} !== 6'b100000)
      begin bad++; $display("FAIL arst_flags got=%b exp=100000", {bus.core_rst, bus.busy, bus.key_evt, bus.cnt_start_dly, bus.cnt_last, bus.cnt_over}); end
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    while (bus.core_rst !== 1'b0 && w < 10) begin @(negedge clk); w++; end
    total++; if (bus.core_rst !== 1'b0) begin bad++; $display("FAIL arst_release got=%0b exp=0", bus.core_rst); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 96; i++) begin
      if (i % 3 == 0) key_i = ~key_i;
      total++; if ({bus.key_evt, bus.core_rst} !== 2'b00)
        begin bad++; $display("FAIL bounce i=%0d evt/rst=%b exp=00", i, {bus.key_evt, bus.core_rst}); end
      @(negedge clk);
    end
  endtask

  task automatic test_sim();
    int w;
    bus_s.free_run_i = 1'b1;
    rst_s = 1'b0;
    @(negedge clk);
    total++; if (bus_s.core_rst !== 1'b1) begin bad++; $display("FAIL sim_hold got=%0b exp=1", bus_s.core_rst); end
    @(negedge clk);
    total++; if (bus_s.core_rst !== 1'b0) begin bad++; $display("FAIL sim_release got=%0b exp=0", bus_s.core_rst); end
    w = 0;
    while (bus_s.cnt !== CW'(9) && w < 30) begin @(negedge clk); w++; end
    total++; if ({bus_s.busy, bus_s.cnt} !== {1'b1, CW'(9)}) begin bad++; $display("FAIL sim_reach busy=%0b cnt=%0d exp 1/9", bus_s.busy, bus_s.cnt); end
    #2 rst_s = 1'b1;
    #1;
    total++; if ({bus_s.core_rst, bus_s.busy, bus_s.cnt} !== {2'b10, CW'(0)})
      begin bad++; $display("FAIL sim_arst rst/busy=%b cnt=%0d exp 10/0", {bus_s.core_rst, bus_s.busy}, bus_s.cnt); end
    @(negedge clk);
    rst_s = 1'b0;
    repeat (2) @(negedge clk);
    // one-clock press followed by release: event after 5 low samples
    key_s = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) key_s = 1'b0;
      if (k <= 10) begin
        total++; if ({bus_s.key_evt, bus_s.core_rst} !== {(k == 9), (k == 9)})
          begin bad++; $display("FAIL sim_key k=%0d evt/rst=%b exp=%b", k, {bus_s.key_evt, bus_s.core_rst}, {(k == 9), (k == 9)}); end
      end
      if (k == 10) begin
        total++; if ({bus_s.busy, bus_s.cnt} !== {1'b0, CW'(0)}) begin bad++; $display("FAIL sim_abort busy=%0b cnt=%0d exp 0/0", bus_s.busy, bus_s.cnt); end
      end
      if (k == 11) begin
        total++; if ({bus_s.busy, bus_s.cnt} !== {1'b1, CW'(0)}) begin bad++; $display("FAIL sim_restart busy=%0b cnt=%0d exp 1/0", bus_s.busy, bus_s.cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_triggered();
    test_key();
    test_async_reset();
    test_bounce();
    test_sim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
